// File: rtl/hit_bitmap_readout_if.sv
`default_nettype none
// ============================================================================
//  Module   : hit_bitmap_readout_if
//  Purpose  : Valid/ready hit-address stream from the bitmap reader to the
//             downstream hit-list / road-matching logic.
//  Revision : 1.0 - initial release
// ============================================================================
interface hit_bitmap_readout_if #(
    parameter int ADDRBITS = 10
) ();
    logic [ADDRBITS-1:0] address;
    logic                addressValid;
    logic                addressReady;

    // Producer side (the bitmap reader).
    modport master (
        output address,
        output addressValid,
        input  addressReady
    );

    // Consumer side (hit-list logic).
    modport slave (
        input  address,
        input  addressValid,
        output addressReady
    );
endinterface
`default_nettype wire

// File: rtl/hit_bitmap_readout.sv
`default_nettype none
// ============================================================================
//  Module   : hit_bitmap_readout
//  Purpose  : Scans every row of the hit-bitmap RAM after a start pulse and
//             emits one {row, col} hit address per set bit over a valid/ready
//             stream, ascending row then ascending column.
//  Options  : CLEAR_ON_READ_EN - zero each row in the cycle after it is read.
//  Revision : 1.0 - initial release
// ============================================================================
module hit_bitmap_readout #(
    parameter int WORDLENGTH   = 16,
    parameter int COLINDEXBITS = 4,
    parameter int ROWINDEXBITS = 6,
    parameter int MEMNROWS     = 64
) (
    input  wire logic                                   clock,
    input  wire logic                                   resetN,
    input  wire logic                                   startReadout,
    output logic                                        readoutBusy,
    output logic                                        readoutDone,
    output logic [ROWINDEXBITS-1:0]                     memRowIndex,
    output logic                                        memReadEnable,
    input  wire logic [WORDLENGTH-1:0]                  memReadData,
    output logic                                        memWriteEnable,
    output logic [WORDLENGTH-1:0]                       memWriteData,
    output logic [ROWINDEXBITS+COLINDEXBITS:0]          hitCount,
    hit_bitmap_readout_if.master                        hitStream
);

    localparam int                      HITBITS  = ROWINDEXBITS + COLINDEXBITS + 1;
    localparam logic [ROWINDEXBITS-1:0] LAST_ROW = ROWINDEXBITS'(MEMNROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                                 state_q, state_d;
    logic [ROWINDEXBITS-1:0]                row_q, row_d;
    logic [WORDLENGTH-1:0]                  pend_q, pend_d;
    logic [ROWINDEXBITS+COLINDEXBITS-1:0]   addr_q, addr_d;
    logic                                   valid_q, valid_d;
    logic [HITBITS-1:0]                     hit_q, hit_d;
    logic [WORDLENGTH-1:0]                  pend_clr;

    // Index of the lowest set bit; 0 for an all-zero word (never used then).
    function automatic logic [COLINDEXBITS-1:0] lowest_set(input logic [WORDLENGTH-1:0] v);
        lowest_set = '0;
        for (int i = WORDLENGTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = COLINDEXBITS'(i);
        end
    endfunction

    // The presented address is always the lowest pending bit, so clearing the
    // lowest set bit retires exactly the address being handed over.
    assign pend_clr = pend_q & (pend_q - WORDLENGTH'(1));

    // State and datapath registers; reset abandons any scan in progress.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            row_q   <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic: fetch/latch each row, drain its set bits, then advance.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        hit_d   = hit_q;
        case (state_q)
            IDLE: begin
                if (startReadout) begin
                    state_d = FETCH;
                    row_d   = '0;
                    hit_d   = '0;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                pend_d = memReadData;
                if (memReadData != '0) begin
                    state_d = SCAN;
                    addr_d  = {row_q, lowest_set(memReadData)};
                    valid_d = 1'b1;
                end else if (row_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = FETCH;
                end
            end
            SCAN: begin
                if (valid_q && hitStream.addressReady) begin
                    pend_d = pend_clr;
                    if (hit_q != {HITBITS{1'b1}}) hit_d = hit_q + 1'b1;
                    if (pend_clr == '0) begin
                        valid_d = 1'b0;
                        if (row_q == LAST_ROW) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        addr_d = {row_q, lowest_set(pend_clr)};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM port strobes and status outputs decoded from the current state.
    always_comb begin
        memReadEnable  = (state_q == FETCH);
        memRowIndex    = '0;
        memWriteEnable = 1'b0;
        memWriteData   = '0;
        if (state_q == FETCH) memRowIndex = row_q;
`ifdef CLEAR_ON_READ_EN
        if (state_q == LATCH) begin
            memWriteEnable = 1'b1;
            memRowIndex    = row_q;
        end
`endif
        readoutBusy = (state_q == FETCH) || (state_q == LATCH) || (state_q == SCAN);
        readoutDone = (state_q == DONE);
    end

    assign hitStream.address      = addr_q;
    assign hitStream.addressValid = valid_q;
    assign hitCount               = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_bitmap_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hit_bitmap_readout
//  Purpose  : Self-checking bench for hit_bitmap_readout: bitmap RAM model,
//             reference hit list built from a golden bitmap copy, and an
//             address scoreboard fed by a decoupled stream monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hit_bitmap_readout;

    localparam int WL    = 16;
    localparam int CB    = 4;
    localparam int RB    = 6;
    localparam int NROWS = 64;
`ifdef CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic              clock;
    logic              resetN;
    logic              startReadout;
    logic              readoutBusy;
    logic              readoutDone;
    logic [RB-1:0]     memRowIndex;
    logic              memReadEnable;
    logic [WL-1:0]     memReadData;
    logic              memWriteEnable;
    logic [WL-1:0]     memWriteData;
    logic [RB+CB:0]    hitCount;

    hit_bitmap_readout_if #(.ADDRBITS(RB + CB)) aif ();

    hit_bitmap_readout #(
        .WORDLENGTH   (WL),
        .COLINDEXBITS (CB),
        .ROWINDEXBITS (RB),
        .MEMNROWS     (NROWS)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .startReadout   (startReadout),
        .readoutBusy    (readoutBusy),
        .readoutDone    (readoutDone),
        .memRowIndex    (memRowIndex),
        .memReadEnable  (memReadEnable),
        .memReadData    (memReadData),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .hitCount       (hitCount),
        .hitStream      (aif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- bitmap RAM model (1-cycle read latency) ----------------
    logic [WL-1:0] mem [NROWS];
    logic [WL-1:0] ref_mem [NROWS];
    logic          ld_en;
    logic [RB-1:0] ld_row;
    logic [WL-1:0] ld_data;

    always @(posedge clock) begin
        if (memReadEnable) memReadData <= mem[memRowIndex];
        if (ld_en) mem[ld_row] <= ld_data;
        else if (memWriteEnable) mem[memRowIndex] <= memWriteData;
    end

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    logic [RB+CB-1:0] exp_q [$];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall on 0x054
    int stall_cnt  = 0;
    int stall_lim  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream ready driver.
    initial begin
        aif.addressReady = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: aif.addressReady = 1'b1;
                1: aif.addressReady = ($urandom_range(0, 3) != 0);
                default: begin
                    if (aif.addressValid && aif.address == 10'h054 && stall_cnt < stall_lim) begin
                        aif.addressReady = 1'b0;
                        stall_cnt++;
                    end else begin
                        aif.addressReady = 1'b1;
                    end
                end
            endcase
        end
    end

    // Stream monitor: hold-stability check and scoreboard pop on handshake.
    logic             held;
    logic [RB+CB-1:0] held_addr;
    logic [RB+CB-1:0] exp_a;
    initial begin
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 32'(aif.addressValid), 32'd1);
                    if (aif.addressValid) check("hold_addr", 32'(aif.address), 32'(held_addr));
                end
                if (aif.addressValid && aif.addressReady) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_addr", 32'(aif.address), 32'hFFFF_FFFF);
                    end else begin
                        exp_a = exp_q.pop_front();
                        check("addr", 32'(aif.address), 32'(exp_a));
                    end
                end
                held      = aif.addressValid && !aif.addressReady;
                held_addr = aif.address;
            end
        end
    end

    // Copy the golden bitmap into the RAM model, one row per cycle.
    task automatic load_ram();
        for (int r = 0; r < NROWS; r++) begin
            @(posedge clock);
            #1;
            ld_en   = 1'b1;
            ld_row  = RB'(r);
            ld_data = ref_mem[r];
        end
        @(posedge clock);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_ref();
        for (int r = 0; r < NROWS; r++) ref_mem[r] = '0;
    endtask

    task automatic check_ram(input string name);
        int bad = 0;
        for (int r = 0; r < NROWS; r++) if (mem[r] !== ref_mem[r]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    // Build the expected hit list from the golden bitmap: ascending row, col.
    function automatic int push_expected();
        int n = 0;
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < WL; c++)
                if (ref_mem[r][c]) begin
                    exp_q.push_back({RB'(r), CB'(c)});
                    n++;
                end
        return n;
    endfunction

    // One complete scan; exp_done / exp_first < 0 skip the cycle checks.
    task automatic run_scan(input string name, input int exp_done, input int exp_first, input bit spur);
        int hits;
        int done_cyc = 0;
        int busy_cnt = 0;
        int we_cnt   = 0;
        int first_v  = 0;
        hits = push_expected();
        @(posedge clock);
        #1 startReadout = 1'b1;
        @(posedge clock);            // edge 0
        #1 startReadout = 1'b0;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clock);
            if (n == 6) startReadout = spur;
            if (n == 7) startReadout = 1'b0;
            if (readoutBusy) busy_cnt++;
            if (memWriteEnable) we_cnt++;
            if (aif.addressValid && first_v == 0) first_v = n;
            if (readoutDone) begin
                done_cyc = n;
                break;
            end
        end
        if (done_cyc == 0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            if (exp_done >= 0)  check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
            if (exp_first >= 0) check({name, "_first_valid"}, 32'(first_v), 32'(exp_first));
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(done_cyc - 1));
            check({name, "_hitcount"}, 32'(hitCount), 32'(hits));
            check({name, "_write_pulses"}, 32'(we_cnt), CLR ? 32'(NROWS) : 32'd0);
            check({name, "_left_in_sb"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            if (CLR) clear_ref();
            @(negedge clock);
            check({name, "_done_pulse_len"}, {30'd0, readoutDone, readoutBusy}, 32'd0);
            check({name, "_hit_hold"}, 32'(hitCount), 32'(hits));
            check_ram({name, "_ram"});
        end
    endtask

    initial begin
        resetN       = 1'b0;
        startReadout = 1'b0;
        ld_en        = 1'b0;
        ld_row       = '0;
        ld_data      = '0;
        clear_ref();
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", 32'(aif.addressValid), 32'd0);
        check("rst_busy_done", {30'd0, readoutBusy, readoutDone}, 32'd0);
        check("rst_hitcount", 32'(hitCount), 32'd0);
        check("rst_mem_strobes", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
        check("rst_rowindex", 32'(memRowIndex), 32'd0);
        check("rst_address", 32'(aif.address), 32'd0);
        resetN = 1'b1;
        load_ram();

        // Empty bitmap.
        ready_mode = 0;
        run_scan("empty", 129, 0, 1'b0);

        // Row 5 = 8011 at full throughput, then a rescan of the same RAM.
        ref_mem[5] = 16'h8011;
        load_ram();
        run_scan("row5", 132, 13, 1'b0);
        run_scan("row5_rescan", CLR ? 129 : 132, CLR ? 0 : 13, 1'b0);

        // Same data, downstream stalls 4 cycles on 0x054.
        clear_ref();
        ref_mem[5] = 16'h8011;
        load_ram();
        ready_mode = 2; stall_cnt = 0; stall_lim = 4;
        run_scan("row5_stall", 136, 13, 1'b0);
        check("stall_cycles_seen", 32'(stall_cnt), 32'd4);

        // Full first and last rows.
        clear_ref();
        ref_mem[0]  = 16'hFFFF;
        ref_mem[63] = 16'hFFFF;
        load_ram();
        ready_mode = 0;
        run_scan("full_rows", 161, 3, 1'b0);

        // Reset while 0x054 is pending.
        begin
            bit seen = 1'b0;
            clear_ref();
            ref_mem[5] = 16'h8011;
            load_ram();
            ready_mode = 2; stall_cnt = 0; stall_lim = 1000;
            void'(push_expected());
            @(posedge clock); #1 startReadout = 1'b1;
            @(posedge clock); #1 startReadout = 1'b0;
            for (int n = 0; n < 300; n++) begin
                @(negedge clock);
                if (aif.addressValid && aif.address == 10'h054) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("abort_reached_054", 32'(seen), 32'd1);
            @(posedge clock);
            #2 resetN = 1'b0;
            #1;
            check("abort_valid_drop", 32'(aif.addressValid), 32'd0);
            check("abort_busy_done", {30'd0, readoutBusy, readoutDone}, 32'd0);
            exp_q.delete();
            stall_lim = 0;
            ready_mode = 0;
            @(posedge clock);
            #1 resetN = 1'b1;
            repeat (2) @(negedge clock);
            check("abort_idle", {30'd0, readoutBusy, memReadEnable}, 32'd0);
            if (CLR) for (int r = 0; r <= 5; r++) ref_mem[r] = '0;
            check_ram("abort_ram");
            run_scan("after_abort", CLR ? 129 : 132, CLR ? 0 : 13, 1'b0);
        end

        // Randomized sparse bitmaps with random back-pressure.
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NROWS; r++)
                ref_mem[r] = ($urandom_range(0, 2) == 0) ? (WL'($urandom) & WL'($urandom)) : '0;
            load_ram();
            ready_mode = 1;
            run_scan("random", -1, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
